// File: rtl/conv_window_fetcher.sv
// conv_window_fetcher: walks a stored image in the single-port image RAM and
// presents successive KxK "valid" convolution windows (stride 1, row-major)
// to the convolution datapath over a valid/ready handshake. Along a row only
// the K pixels of the new right-hand column are read; the rest are shifted.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              begin a pass over the image (sampled only when idle)
//   busy               high from the cycle after start is accepted until done
//   done               one-cycle pulse after the final window handshake
//   rd, adr            RAM read strobe and address (row*IMG_W + col)
//   dataIn             RAM registered read data, valid the cycle after rd
//   winValid, winReady window handshake
//   window             pixel(r,c) at bits [(r*K+c)*WORD_SIZE +: WORD_SIZE]
//   winRow, winCol     top-left coordinate of the presented window
module conv_window_fetcher #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28,
    parameter int unsigned K         = 3,
    localparam int unsigned AW = $clog2(IMG_W * IMG_H),
    localparam int unsigned RW = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1,
    localparam int unsigned CW = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1,
    localparam int unsigned WW = K * K * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd,
    output logic [AW-1:0]        adr,
    input  logic [WORD_SIZE-1:0] dataIn,
    output logic                 winValid,
    input  logic                 winReady,
    output logic [WW-1:0]        window,
    output logic [RW-1:0]        winRow,
    output logic [CW-1:0]        winCol
);

    localparam int unsigned SW = $clog2(K * K);
    localparam int unsigned IW = $clog2(K + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SLIDE = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_n;
    logic                busy_n, done_n, rd_n, win_valid_n;
    logic [AW-1:0]       adr_n;
    logic [WW-1:0]       window_n;
    logic [RW-1:0]       row_n;
    logic [CW-1:0]       col_n;
    // Next read to issue within the current window (row offset, column offset).
    logic [IW-1:0]       iss_r, iss_r_n, iss_c, iss_c_n;
    // Window slot of the read on the bus, and of the word arriving on dataIn.
    logic [SW-1:0]       rd_slot, rd_slot_n, cap_slot, cap_slot_n;
    logic                cap_en, cap_en_n;

    function automatic logic [AW-1:0] addr_of(input int unsigned r, input int unsigned c);
        return AW'(r * IMG_W + c);
    endfunction

    function automatic logic [SW-1:0] slot_of(input int unsigned r, input int unsigned c);
        return SW'(r * K + c);
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd       <= 1'b0;
            adr      <= '0;
            winValid <= 1'b0;
            window   <= '0;
            winRow   <= '0;
            winCol   <= '0;
            iss_r    <= '0;
            iss_c    <= '0;
            rd_slot  <= '0;
            cap_slot <= '0;
            cap_en   <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            done     <= done_n;
            rd       <= rd_n;
            adr      <= adr_n;
            winValid <= win_valid_n;
            window   <= window_n;
            winRow   <= row_n;
            winCol   <= col_n;
            iss_r    <= iss_r_n;
            iss_c    <= iss_c_n;
            rd_slot  <= rd_slot_n;
            cap_slot <= cap_slot_n;
            cap_en   <= cap_en_n;
        end
    end

    // Next-state, read sequencing and window capture
    always_comb begin
        state_n     = state;
        busy_n      = busy;
        done_n      = 1'b0;
        rd_n        = 1'b0;
        adr_n       = adr;
        win_valid_n = winValid;
        window_n    = window;
        row_n       = winRow;
        col_n       = winCol;
        iss_r_n     = iss_r;
        iss_c_n     = iss_c;
        rd_slot_n   = rd_slot;
        // RAM data lags rd by one cycle, so the capture tags lag it too.
        cap_en_n    = rd;
        cap_slot_n  = rd_slot;

        if (cap_en) begin
            window_n[32'(cap_slot) * WORD_SIZE +: WORD_SIZE] = dataIn;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = FILL;
                    busy_n    = 1'b1;
                    row_n     = '0;
                    col_n     = '0;
                    rd_n      = 1'b1;
                    adr_n     = addr_of(0, 0);
                    rd_slot_n = '0;
                    iss_r_n   = '0;
                    iss_c_n   = IW'(1);
                end
            end

            FILL: begin
                if (iss_r < IW'(K)) begin
                    rd_n      = 1'b1;
                    adr_n     = addr_of(32'(winRow) + 32'(iss_r), 32'(winCol) + 32'(iss_c));
                    rd_slot_n = slot_of(32'(iss_r), 32'(iss_c));
                    if (iss_c == IW'(K - 1)) begin
                        iss_c_n = '0;
                        iss_r_n = iss_r + IW'(1);
                    end else begin
                        iss_c_n = iss_c + IW'(1);
                    end
                end
                // Both fill and slide finish with the bottom-right slot.
                if (cap_en && cap_slot == SW'(K * K - 1)) begin
                    state_n     = OUT;
                    win_valid_n = 1'b1;
                end
            end

            SLIDE: begin
                if (iss_r < IW'(K)) begin
                    rd_n      = 1'b1;
                    adr_n     = addr_of(32'(winRow) + 32'(iss_r), 32'(winCol) + K - 1);
                    rd_slot_n = slot_of(32'(iss_r), K - 1);
                    iss_r_n   = iss_r + IW'(1);
                end
                if (cap_en && cap_slot == SW'(K * K - 1)) begin
                    state_n     = OUT;
                    win_valid_n = 1'b1;
                end
            end

            OUT: begin
                if (winValid && winReady) begin
                    win_valid_n = 1'b0;
                    if (winCol < CW'(IMG_W - K)) begin
                        // Step right: reuse K-1 columns, fetch the new right column.
                        state_n = SLIDE;
                        col_n   = winCol + CW'(1);
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K - 1; c++) begin
                                window_n[(r * K + c) * WORD_SIZE +: WORD_SIZE] =
                                    window[(r * K + c + 1) * WORD_SIZE +: WORD_SIZE];
                            end
                        end
                        rd_n      = 1'b1;
                        adr_n     = addr_of(32'(winRow), 32'(winCol) + K);
                        rd_slot_n = slot_of(0, K - 1);
                        iss_r_n   = IW'(1);
                    end else if (winRow < RW'(IMG_H - K)) begin
                        state_n   = FILL;
                        row_n     = winRow + RW'(1);
                        col_n     = '0;
                        rd_n      = 1'b1;
                        adr_n     = addr_of(32'(winRow) + 1, 0);
                        rd_slot_n = '0;
                        iss_r_n   = '0;
                        iss_c_n   = IW'(1);
                    end else begin
                        state_n = DONE;
                    end
                end
            end

            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_window_fetcher.sv
// Self-checking bench for conv_window_fetcher: a behavioural RAM plus a
// reference model that derives each expected window and its RAM reads
// directly from the image contents and raster-scan order.
module tb_conv_window_fetcher;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 28;
    localparam int unsigned IH = 28;
    localparam int unsigned K  = 3;
    localparam int unsigned NC = IW - K + 1;
    localparam int unsigned NR = IH - K + 1;
    localparam int unsigned NW = NC * NR;
    localparam int unsigned AW = $clog2(IW * IH);
    localparam int unsigned RW = $clog2(NR);
    localparam int unsigned CW = $clog2(NC);
    localparam int unsigned WW = K * K * W;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd;
    logic [AW-1:0] adr;
    logic [W-1:0]  data_in;
    logic          win_valid;
    logic          win_ready;
    logic [WW-1:0] window;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    logic [W-1:0]  mem [IW * IH];
    int            rd_log[$];
    int            cyc = 0;
    int            start_cyc;
    int            last_hs;
    int            done_cnt;
    int            done_cyc;
    int            n_checks = 0;
    int            n_fail = 0;

    conv_window_fetcher #(.WORD_SIZE(W), .IMG_W(IW), .IMG_H(IH), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd(rd), .adr(adr), .dataIn(data_in), .winValid(win_valid),
        .winReady(win_ready), .window(window), .winRow(win_row), .winCol(win_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Image RAM with registered read port
    always @(posedge clk) if (rd) data_in <= mem[adr];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and record RAM reads / done pulses.
    task automatic tick();
        @(negedge clk);
        if (rd) rd_log.push_back(int'(adr));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    function automatic logic [WW-1:0] model_win(input int wr, input int wc);
        logic [WW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r * K + c) * W +: W] = mem[(wr + r) * IW + wc + c];
        return v;
    endfunction

    // Reads expected since the previous handshake: a full KxK fetch at the
    // start of each row, otherwise just the new right-hand column.
    task automatic check_reads(input int wr, input int wc);
        int exp_q[$];
        int mism;
        if (wc == 0) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    exp_q.push_back((wr + r) * IW + c);
        end else begin
            for (int r = 0; r < K; r++)
                exp_q.push_back((wr + r) * IW + wc + K - 1);
        end
        check($sformatf("rd_count(%0d,%0d)", wr, wc), 128'(rd_log.size()), 128'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < rd_log.size() && i < exp_q.size(); i++)
            if (rd_log[i] != exp_q[i]) mism++;
        check($sformatf("rd_addr_mismatches(%0d,%0d)", wr, wc), 128'(mism), 128'(0));
    endtask

    // Stall the window for 20 cycles; it must stay presented with no reads.
    task automatic backpressure(input int wr, input int wc);
        bit stable;
        stable = 1'b1;
        win_ready = 1'b0;
        repeat (20) begin
            tick();
            if ({win_valid, rd, win_row, win_col, window} !==
                {1'b1, 1'b0, RW'(wr), CW'(wc), model_win(wr, wc)})
                stable = 1'b0;
        end
        check($sformatf("backpressure_hold(%0d,%0d)", wr, wc), 128'(stable), 128'(1));
    endtask

    // One pass from a start pulse; stops after stop_idx handshakes.
    task automatic run_pass(input bit rand_ready, input int bp_idx, input int stop_idx,
                            input bit mid_start, input bit timing);
        int  n, waited, wr, wc;
        bit  seen;
        logic rdy;
        n = 0; waited = 0; seen = 1'b0;
        rd_log.delete();
        done_cnt = 0;
        start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        while (n < stop_idx && waited < LIMIT) begin
            wr = n / NC;
            wc = n % NC;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (win_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (n == 0)
                        check("first_valid_latency", 128'(cyc - start_cyc), 128'(10));
                    check($sformatf("window(%0d,%0d)", wr, wc),
                          128'({busy, win_row, win_col, window}),
                          128'({1'b1, RW'(wr), CW'(wc), model_win(wr, wc)}));
                end
                if (n == bp_idx) begin
                    backpressure(wr, wc);
                    rdy = 1'b1;
                end
                win_ready = rdy;
                if (rdy) begin
                    check_reads(wr, wc);
                    rd_log.delete();
                    n++;
                    seen = 1'b0;
                    last_hs = cyc + 1;
                end
            end else begin
                win_ready = rdy;
            end
            if (mid_start && n == 5) start = 1'b1;
            tick();
            start = 1'b0;
            waited++;
        end
        check("windows_seen", 128'(n), 128'(stop_idx));
        if (stop_idx == NW) begin
            repeat (3) tick();
            check("done_count", 128'(done_cnt), 128'(1));
            check("busy_after_done", 128'(busy), 128'(0));
            if (timing) begin
                check("last_handshake_cycle", 128'(last_hs - start_cyc), 128'(3536));
                check("done_cycle", 128'(done_cyc - start_cyc), 128'(3537));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < IW * IH; a++) mem[a] = 8'(a);
        rst = 1'b1;
        start = 1'b0;
        win_ready = 1'b1;
        tick();
        tick();
        check("reset_state", 128'({busy, done, rd, win_valid, adr, window, win_row, win_col}), 128'(0));
        rst = 1'b0;
        tick();
        tick();
        check("idle_without_start", 128'({busy, rd, win_valid}), 128'(0));

        // Full pass, ready tied high, with cycle-exact timing checks
        run_pass(1'b0, -1, NW, 1'b0, 1'b1);
        tick();

        // Abort during the slide towards window (2,3)
        run_pass(1'b0, -1, 2 * NC + 3, 1'b0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("async_reset_outputs", 128'({busy, done, rd, win_valid, adr, window, win_row, win_col}), 128'(0));
        tick();
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("start_during_reset_ignored", 128'({busy, rd, win_valid}), 128'(0));

        // Random image, random ready, stall at (4,7), stray start while busy
        for (int a = 0; a < IW * IH; a++) mem[a] = 8'($urandom);
        run_pass(1'b1, 4 * NC + 7, NW, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
